sigmoid_rr_scheduler: RTL and testbench

- Shares one fixed-latency PLAN sigmoid core (Q8.8 in, Q8.8 out) between N requesters.
- Uses round-robin arbitration and tracks a requester-ID tag through the core latency.
- Routes each result to a per-requester one-deep result buffer with a valid/ready handshake.
- Sits between the requester front-ends and the shared sigmoid datapath; at most one operation is outstanding per requester.

---
 rtl/sigmoid_rr_scheduler.sv | 110 +++++++++++
 tb/tb_sigmoid_rr_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_rr_scheduler.sv
// Round-robin share of one LAT-cycle sigmoid core among N requesters; results land in one-deep per-requester buffers.
// Accept t -> core_vld t+1 -> res_vld t+2+LAT; full buffer or pending op blocks its requester. Option: SIG_SAT_BYPASS_EN.
module sigmoid_rr_scheduler #(
  parameter int N   = 4,
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req_vld,
  input  logic [16*N-1:0] req_x,
  output logic [N-1:0]    req_rdy,
  output logic            core_vld,
  output logic [15:0]     core_x,
  input  logic [15:0]     core_y,
  output logic [N-1:0]    res_vld,
  output logic [16*N-1:0] res_y,
  input  logic [N-1:0]    res_rdy,
  output logic            busy
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [IDW-1:0] ptr;
  logic [N-1:0]   pend;
  logic [LAT:0]   tag_v;
  logic [IDW-1:0] tag_id [LAT+1];

  logic [N-1:0]   elig;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic [15:0]    gx;
  logic           byp;
  logic [15:0]    byp_y;

  assign elig = {N{en & ~rst}} & req_vld & ~pend & ~res_vld;
  assign busy = (|pend) | (|res_vld);

  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    gx        = '0;
    req_rdy   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
        gx        = req_x[16*idx +: 16];
      end
    end
    req_rdy[grant_id] = grant_vld;
  end

  // Saturated operands resolve without the core: sigmoid is 1.0 / 0.0 to Q8.8 precision.
  always_comb begin
    byp   = 1'b0;
    byp_y = '0;
`ifdef SIG_SAT_BYPASS_EN
    if (!gx[15] && gx[14:11] != 4'd0) begin
      byp   = 1'b1;
      byp_y = 16'h0100;
    end else if (gx[15] && gx <= 16'hF800) begin
      byp   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= IDW'(N - 1);
      pend     <= '0;
      tag_v    <= '0;
      for (int s = 0; s <= LAT; s++) tag_id[s] <= '0;
      core_vld <= 1'b0;
      core_x   <= '0;
      res_vld  <= '0;
      res_y    <= '0;
    end else begin
      core_vld <= 1'b0;
      tag_v    <= {tag_v[LAT-1:0], 1'b0};
      for (int s = 1; s <= LAT; s++) tag_id[s] <= tag_id[s-1];
      res_vld  <= res_vld & ~res_rdy;

      // Last tag stage lines up with core_y for the op issued LAT cycles earlier.
      if (tag_v[LAT]) begin
        res_y[16*int'(tag_id[LAT]) +: 16] <= core_y;
        res_vld[tag_id[LAT]]              <= 1'b1;
        pend[tag_id[LAT]]                 <= 1'b0;
      end

      if (grant_vld) begin
        ptr <= grant_id;
        if (byp) begin
          res_y[16*int'(grant_id) +: 16] <= byp_y;
          res_vld[grant_id]              <= 1'b1;
        end else begin
          pend[grant_id] <= 1'b1;
          core_x         <= gx;
          core_vld       <= 1'b1;
          tag_v[0]       <= 1'b1;
          tag_id[0]      <= grant_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_rr_scheduler.sv
// Directed bench for sigmoid_rr_scheduler (N=4, LAT=1); the stand-in core returns x + 0x0080 one cycle after core_vld.
module tb_sigmoid_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_vld;
  logic [63:0] req_x;
  logic [3:0]  req_rdy;
  logic        core_vld;
  logic [15:0] core_x;
  logic [15:0] core_y = 16'h0000;
  logic [3:0]  res_vld;
  logic [63:0] res_y;
  logic [3:0]  res_rdy;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sigmoid_rr_scheduler #(.N(4), .LAT(1)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .core_vld(core_vld), .core_x(core_x), .core_y(core_y),
    .res_vld(res_vld), .res_y(res_y), .res_rdy(res_rdy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (core_vld) core_y <= core_x + 16'h0080;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b1; req_vld = '0; res_rdy = 4'hF;
    tick; tick;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; req_vld = 4'hF; res_rdy = 4'hF; req_x = '0;
    for (int c = 0; c < 2; c++) begin
      tick;
      checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_req_rdy: got %b expected 0000", req_rdy); end
      checks++; if (core_vld !== 1'b0) begin errors++; $display("FAIL reset_core_vld: got %b expected 0", core_vld); end
      checks++; if (core_x !== 16'h0000) begin errors++; $display("FAIL reset_core_x: got %h expected 0000", core_x); end
      checks++; if (res_vld !== 4'b0000) begin errors++; $display("FAIL reset_res_vld: got %b expected 0000", res_vld); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    end
    rst = 1'b0;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", req_rdy); end
    do_reset;
  endtask

  task automatic test_enable;
    en = 1'b0; req_vld = 4'hF;
    #1;
    checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL en_low_req_rdy: got %b expected 0000", req_rdy); end
    tick;
    checks++; if (core_vld !== 1'b0) begin errors++; $display("FAIL en_low_core_vld: got %b expected 0", core_vld); end
    en = 1'b1; req_vld = '0;
    #1;
  endtask

  task automatic test_single;
    do_reset;
    res_rdy = 4'b0000; req_x[31:16] = 16'h0000; req_vld = 4'b0010;
    #1;
    checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL single_req_rdy: got %b expected 0010", req_rdy); end
    tick;
    req_vld = '0;
    checks++; if (core_vld !== 1'b1) begin errors++; $display("FAIL single_core_vld: got %b expected 1", core_vld); end
    checks++; if (core_x !== 16'h0000) begin errors++; $display("FAIL single_core_x: got %h expected 0000", core_x); end
    checks++; if (res_vld !== 4'b0000) begin errors++; $display("FAIL single_res_early_t1: got %b expected 0000", res_vld); end
    tick;
    checks++; if (res_vld !== 4'b0000) begin errors++; $display("FAIL single_res_early_t2: got %b expected 0000", res_vld); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_pend: got %b expected 1", busy); end
    tick;
    checks++; if (res_vld !== 4'b0010) begin errors++; $display("FAIL single_res_vld: got %b expected 0010", res_vld); end
    checks++; if (res_y[31:16] !== 16'h0080) begin errors++; $display("FAIL single_res_y: got %h expected 0080", res_y[31:16]); end
    res_rdy = 4'hF;
    tick;
    checks++; if (res_vld !== 4'b0000) begin errors++; $display("FAIL single_pop: got %b expected 0000", res_vld); end
    checks++; if (res_y[31:16] !== 16'h0080) begin errors++; $display("FAIL single_res_hold: got %h expected 0080", res_y[31:16]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_x;
    int r;
    do_reset;
    for (int i = 0; i < 4; i++) req_x[16*i +: 16] = 16'(i * 256);
    req_vld = 4'hF; res_rdy = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      checks++; if (req_rdy !== exp_rdy) begin errors++; $display("FAIL rr_grant_c%0d: got %b expected %b", k, req_rdy, exp_rdy); end
      if (k >= 1) begin
        exp_x = 16'(((k - 1) % 4) * 256);
        checks++; if (core_vld !== 1'b1 || core_x !== exp_x) begin errors++; $display("FAIL rr_issue_c%0d: got vld=%b x=%h expected vld=1 x=%h", k, core_vld, core_x, exp_x); end
      end
      if (k >= 3) begin
        r = (k - 3) % 4;
        checks++; if (res_vld !== (4'b0001 << r)) begin errors++; $display("FAIL rr_res_vld_c%0d: got %b expected %b", k, res_vld, 4'b0001 << r); end
        checks++; if (res_y[16*r +: 16] !== 16'(r * 256 + 128)) begin errors++; $display("FAIL rr_res_y_c%0d: got %h expected %h", k, res_y[16*r +: 16], 16'(r * 256 + 128)); end
      end
      tick;
    end
    req_vld = '0;
    for (int c = 0; c < 6; c++) tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain_busy: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure;
    do_reset;
    res_rdy = 4'b0000; req_x[47:32] = 16'h0123; req_vld = 4'b0100;
    #1;
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL bp_first_grant: got %b expected 0100", req_rdy); end
    tick; tick; tick;
    for (int c = 0; c < 10; c++) begin
      checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL bp_no_grant_c%0d: got %b expected 0000", c, req_rdy); end
      checks++; if (res_vld !== 4'b0100 || res_y[47:32] !== 16'h01A3) begin errors++; $display("FAIL bp_hold_c%0d: got vld=%b y=%h expected vld=0100 y=01a3", c, res_vld, res_y[47:32]); end
      tick;
    end
    res_rdy = 4'b0100;
    #1;
    checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL bp_pop_cycle: got %b expected 0000", req_rdy); end
    tick;
    res_rdy = 4'b0000;
    #1;
    checks++; if (res_vld !== 4'b0000) begin errors++; $display("FAIL bp_popped: got %b expected 0000", res_vld); end
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL bp_regrant: got %b expected 0100", req_rdy); end
    req_vld = '0;
  endtask

  task automatic test_reset_midflight;
    do_reset;
    res_rdy = 4'b0000; req_x[63:48] = 16'h0040; req_vld = 4'b1000;
    #1;
    checks++; if (req_rdy !== 4'b1000) begin errors++; $display("FAIL mid_grant: got %b expected 1000", req_rdy); end
    tick;
    req_vld = '0; rst = 1'b1;
    checks++; if (core_vld !== 1'b1) begin errors++; $display("FAIL mid_core_vld: got %b expected 1", core_vld); end
    tick;
    rst = 1'b0;
    checks++; if (core_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after_reset: got vld=%b busy=%b expected 0 0", core_vld, busy); end
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (res_vld !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mid_discard_c%0d: got res_vld=%b busy=%b expected 0000 0", c, res_vld, busy); end
    end
  endtask

  task automatic test_bypass;
    do_reset;
    res_rdy = 4'b0000; req_x[15:0] = 16'h0900; req_x[31:16] = 16'hF700; req_vld = 4'b0011;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL byp_grant0: got %b expected 0001", req_rdy); end
    tick;
    checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL byp_grant1: got %b expected 0010", req_rdy); end
`ifdef SIG_SAT_BYPASS_EN
    checks++; if (core_vld !== 1'b0 || res_vld !== 4'b0001 || res_y[15:0] !== 16'h0100) begin errors++; $display("FAIL byp_pos: got core_vld=%b res_vld=%b y=%h expected 0 0001 0100", core_vld, res_vld, res_y[15:0]); end
    tick;
    req_vld = '0;
    checks++; if (core_vld !== 1'b0 || res_vld !== 4'b0011 || res_y[31:16] !== 16'h0000) begin errors++; $display("FAIL byp_neg: got core_vld=%b res_vld=%b y=%h expected 0 0011 0000", core_vld, res_vld, res_y[31:16]); end
`else
    checks++; if (core_vld !== 1'b1 || core_x !== 16'h0900) begin errors++; $display("FAIL nobyp_issue0: got vld=%b x=%h expected 1 0900", core_vld, core_x); end
    tick;
    req_vld = '0;
    checks++; if (core_vld !== 1'b1 || core_x !== 16'hF700) begin errors++; $display("FAIL nobyp_issue1: got vld=%b x=%h expected 1 f700", core_vld, core_x); end
    tick;
    checks++; if (res_vld !== 4'b0001 || res_y[15:0] !== 16'h0980) begin errors++; $display("FAIL nobyp_res0: got vld=%b y=%h expected 0001 0980", res_vld, res_y[15:0]); end
    tick;
    checks++; if (res_vld !== 4'b0011 || res_y[31:16] !== 16'hF780) begin errors++; $display("FAIL nobyp_res1: got vld=%b y=%h expected 0011 f780", res_vld, res_y[31:16]); end
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req_vld = '0; req_x = '0; res_rdy = 4'hF;
    test_reset;
    test_enable;
    test_single;
    test_round_robin;
    test_backpressure;
    test_reset_midflight;
    test_bypass;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
